// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the core MEM stage and a debug/loader port.
// Define DMEM_ARB_RR_EN for round-robin conflict resolution instead of core priority with a starvation guard.
module dmem_port_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned MEM_WORDS    = 4096,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         core_req_i,
    input  logic                         core_we_i,
    input  logic [3:0]                   core_be_i,
    input  logic [XLEN-1:0]              core_addr_i,
    input  logic [XLEN-1:0]              core_wdata_i,
    output logic                         core_gnt_o,
    output logic                         core_stall_o,
    output logic                         core_rvalid_o,
    output logic [XLEN-1:0]              core_rdata_o,
    input  logic                         dbg_req_i,
    input  logic                         dbg_we_i,
    input  logic [3:0]                   dbg_be_i,
    input  logic [XLEN-1:0]              dbg_addr_i,
    input  logic [XLEN-1:0]              dbg_wdata_i,
    output logic                         dbg_gnt_o,
    output logic                         dbg_rvalid_o,
    output logic [XLEN-1:0]              dbg_rdata_o,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [3:0]                   mem_be_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    output logic [XLEN-1:0]              mem_wdata_o,
    input  logic [XLEN-1:0]              mem_rdata_i,
    output logic [15:0]                  conflict_cnt_o
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam logic [7:0] StarveLim = 8'(STARVE_LIMIT);

    typedef enum logic [0:0] {ArbCore, ArbDbg} arb_state_e;

    arb_state_e  state_q, state_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic        rd_core_q, rd_dbg_q;
    logic        conflict, dbg_wins;
`ifdef DMEM_ARB_RR_EN
    logic        prio_dbg_q, prio_dbg_d;
`endif

    // Only the word index is used; byte lanes come from be.
    logic unused_addr;
    assign unused_addr = ^{core_addr_i[XLEN-1:AW+2], core_addr_i[1:0],
                           dbg_addr_i[XLEN-1:AW+2], dbg_addr_i[1:0]};

    always_comb begin
        conflict = core_req_i & dbg_req_i;
`ifdef DMEM_ARB_RR_EN
        dbg_wins = dbg_req_i & (~core_req_i | prio_dbg_q);
`else
        dbg_wins = dbg_req_i & (~core_req_i | (state_q == ArbDbg));
`endif
        dbg_gnt_o    = dbg_wins;
        core_gnt_o   = core_req_i & ~dbg_wins;
        core_stall_o = core_req_i & ~core_gnt_o;

        mem_req_o   = core_gnt_o | dbg_gnt_o;
        mem_we_o    = dbg_gnt_o ? dbg_we_i : (core_gnt_o & core_we_i);
        mem_be_o    = dbg_gnt_o ? dbg_be_i : core_be_i;
        mem_addr_o  = dbg_gnt_o ? dbg_addr_i[AW+1:2] : core_addr_i[AW+1:2];
        mem_wdata_o = dbg_gnt_o ? dbg_wdata_i : core_wdata_i;

        core_rvalid_o  = rd_core_q;
        dbg_rvalid_o   = rd_dbg_q;
        core_rdata_o   = rd_core_q ? mem_rdata_i : '0;
        dbg_rdata_o    = rd_dbg_q ? mem_rdata_i : '0;
        conflict_cnt_o = conflict_cnt_q;
    end

    always_comb begin
        state_d        = state_q;
        starve_cnt_d   = starve_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        if (conflict && conflict_cnt_q != 16'hFFFF) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
`ifdef DMEM_ARB_RR_EN
        // The loser of a conflict gets priority at the next conflict.
        prio_dbg_d   = conflict ? core_gnt_o : prio_dbg_q;
        state_d      = ArbCore;
        starve_cnt_d = 8'd0;
`else
        if (dbg_gnt_o) begin
            starve_cnt_d = 8'd0;
        end else if (dbg_req_i && starve_cnt_q != 8'hFF) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
        unique case (state_q)
            ArbCore: begin
                if (starve_cnt_d >= StarveLim) state_d = ArbDbg;
            end
            ArbDbg: begin
                if (dbg_gnt_o) begin
                    state_d = ArbCore;
                end else if (!dbg_req_i) begin
                    state_d      = ArbCore;
                    starve_cnt_d = 8'd0;
                end
            end
            default: state_d = ArbCore;
        endcase
`endif
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= ArbCore;
            starve_cnt_q   <= 8'd0;
            conflict_cnt_q <= 16'd0;
            rd_core_q      <= 1'b0;
            rd_dbg_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            starve_cnt_q   <= starve_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
            rd_core_q      <= core_gnt_o & ~core_we_i;
            rd_dbg_q       <= dbg_gnt_o & ~dbg_we_i;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) prio_dbg_q <= 1'b0;
        else         prio_dbg_q <= prio_dbg_d;
    end
`endif

endmodule
